pixel_display_driver: RTL and testbench



---
 rtl/pixel_display_driver.sv | 228 ++++++++++++++++++++++
 tb/tb_pixel_display_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_display_driver.sv
// pixel_display_driver
// Time-multiplexed hex seven-segment driver. It captures the pixel-memory read
// word handed from the memory stage to write-back, then scans it nibble by
// nibble onto a shared segment bus with a rotating one-hot digit select.
// While halt is high the captured word is frozen (HOLD).
// Optional feature macro: PIXEL_DISPLAY_BLINK_EN. When it is defined, the
// segments blink in HOLD with a half-period of BLINK_SCANS full scan rounds.
module pixel_display_driver #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_DIGITS  = 6,
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_SCANS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  hold_active,
  output logic [15:0]           update_count
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W   = $clog2(REFRESH_DIV);
  localparam int BLINK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Nibble to active-high segments {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [15:0]             count_q, count_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    hold_q, hold_d;
  logic                    accept;
  logic                    scan_wrap;
  logic [3:0]              nib;
  logic                    blank;

  // Control FSM, capture path, saturating counter and scan counters.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    div_d   = div_q;
    idx_d   = idx_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pix_valid && !halt) begin
          state_d = SHOW;
          accept  = 1'b1;
        end
      end
      SHOW: begin
        if (halt) begin
          state_d = HOLD;
        end else if (pix_valid) begin
          accept = 1'b1;
        end
      end
      HOLD: begin
        if (!halt) begin
          state_d = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      data_d = pix_data;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end

    // The scan keeps running across SHOW/HOLD transitions; only IDLE parks it.
    scan_wrap = 1'b0;
    if (state_q == IDLE) begin
      div_d = '0;
      idx_d = '0;
    end else if (div_q == DIV_MAX) begin
      div_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d     = '0;
        scan_wrap = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

`ifdef PIXEL_DISPLAY_BLINK_EN
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_SCANS - 1);

  logic               blink_phase_q, blink_phase_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

  // Blink phase: restarts visible on each HOLD entry, toggles every BLINK_SCANS scan rounds.
  always_comb begin
    blink_phase_d = blink_phase_q;
    blink_cnt_d   = blink_cnt_q;
    if (state_d != HOLD || state_q != HOLD) begin
      blink_phase_d = 1'b1;
      blink_cnt_d   = '0;
    end else if (scan_wrap) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_phase_q <= 1'b1;
      blink_cnt_q   <= '0;
    end else begin
      blink_phase_q <= blink_phase_d;
      blink_cnt_q   <= blink_cnt_d;
    end
  end

  assign blank = (state_q == HOLD) && !blink_phase_q;
`else
  logic [BLINK_W-1:0] unused_blink;
  logic               unused_wrap;
  assign unused_blink = '0;
  assign unused_wrap  = scan_wrap;
  assign blank        = 1'b0;
`endif

  // Registered display outputs built from the current digit index and held word.
  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib = data_q[4*k +: 4];
      end
    end
    sel_d = '0;
    seg_d = 7'b0;
    if (state_q != IDLE) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        sel_d[k] = (idx_q == IDX_W'(k));
      end
      seg_d = blank ? 7'b0 : hex_to_seg(nib);
    end
    hold_d = (state_q == HOLD);
  end

  generate
    if (DATA_WIDTH > 4 * NUM_DIGITS) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^data_q[DATA_WIDTH-1:4*NUM_DIGITS];
    end
  endgenerate

  // State, data and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      sel_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  assign seg          = seg_q;
  assign digit_sel    = sel_q;
  assign hold_active  = hold_q;
  assign update_count = count_q;

endmodule

// File: tb/tb_pixel_display_driver.sv
// Testbench for pixel_display_driver with REFRESH_DIV=4, NUM_DIGITS=6.
// Table-driven scan vectors plus directed HOLD, overwrite, reset and
// saturation sequences.
module tb_pixel_display_driver;

  localparam int DW = 32;
  localparam int ND = 6;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          halt;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic [6:0]    seg;
  logic [ND-1:0] digit_sel;
  logic          hold_active;
  logic [15:0]   update_count;

  typedef struct packed {
    logic [31:0]     data;
    logic [5:0][6:0] segs;
  } vec_t;

  vec_t tbl [3];
  int   checks   = 0;
  int   failures = 0;

  pixel_display_driver #(
    .DATA_WIDTH (DW),
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .BLINK_SCANS(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .seg         (seg),
    .digit_sel   (digit_sel),
    .hold_active (hold_active),
    .update_count(update_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    halt      = 1'b0;
    pix_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // c = number of edges after the capture edge; the outputs show digit ((c-1)/RD)%ND.
  task automatic scan_check(input int c, input vec_t v, input string tag);
    logic [5:0] es;
    int         d;
    d  = ((c - 1) / RD) % ND;
    es = 6'b000001 << d;
    chk($sformatf("%s_sel_c%0d", tag, c), 32'(digit_sel), 32'(es));
    chk($sformatf("%s_seg_c%0d", tag, c), 32'(seg), 32'(v.segs[d]));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h0);
    chk({tag, "_sel"}, 32'(digit_sel), 32'h0);
    chk({tag, "_hold"}, 32'(hold_active), 32'h0);
    chk({tag, "_count"}, 32'(update_count), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0].data    = 32'h00FEDCBA;
    tbl[0].segs[0] = 7'b1110111;
    tbl[0].segs[1] = 7'b0011111;
    tbl[0].segs[2] = 7'b1001110;
    tbl[0].segs[3] = 7'b0111101;
    tbl[0].segs[4] = 7'b1001111;
    tbl[0].segs[5] = 7'b1000111;
    tbl[1].data    = 32'h00123456;
    tbl[1].segs[0] = 7'b1011111;
    tbl[1].segs[1] = 7'b1011011;
    tbl[1].segs[2] = 7'b0110011;
    tbl[1].segs[3] = 7'b1111001;
    tbl[1].segs[4] = 7'b1101101;
    tbl[1].segs[5] = 7'b0110000;
    tbl[2].data    = 32'hFF789000;
    tbl[2].segs[0] = 7'b1111110;
    tbl[2].segs[1] = 7'b1111110;
    tbl[2].segs[2] = 7'b1111110;
    tbl[2].segs[3] = 7'b1111011;
    tbl[2].segs[4] = 7'b1111111;
    tbl[2].segs[5] = 7'b1110000;

    reset     = 1'b1;
    halt      = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_zero("reset");

    repeat (20) tick();
    chk_zero("idle20");

    // Strobes while halted in IDLE are discarded.
    halt      = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 32'h00FEDCBA;
    tick();
    tick();
    halt      = 1'b0;
    pix_valid = 1'b0;
    tick();
    tick();
    chk_zero("idle_halt");

    // Table-driven scan of each vector from a fresh capture.
    for (int i = 0; i < 3; i++) begin
      do_reset();
      pix_data  = tbl[i].data;
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      for (int c = 1; c <= 28; c++) begin
        tick();
        scan_check(c, tbl[i], $sformatf("vec%0d", i));
      end
      chk($sformatf("vec%0d_count", i), 32'(update_count), 32'd1);
    end

    // HOLD entry with a simultaneous strobe, steady display, then release.
    do_reset();
    pix_data  = tbl[0].data;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      scan_check(c, tbl[0], "pre_hold");
    end
    halt      = 1'b1;
    pix_valid = 1'b1;
    pix_data  = tbl[1].data;
    tick();
    scan_check(11, tbl[0], "hold_entry");
    chk("hold_active_entry_edge", 32'(hold_active), 32'd0);
    pix_valid = 1'b0;
    for (int c = 12; c <= 40; c++) begin
      tick();
      scan_check(c, tbl[0], "hold");
      if (c == 12) chk("hold_active_rise", 32'(hold_active), 32'd1);
    end
    chk("hold_count", 32'(update_count), 32'd1);
    halt = 1'b0;
    tick();
    scan_check(41, tbl[0], "release");
    chk("hold_active_release_edge", 32'(hold_active), 32'd1);
    tick();
    scan_check(42, tbl[0], "release");
    chk("hold_active_fall", 32'(hold_active), 32'd0);

    // Overwrite while SHOW: new word appears one edge after capture, scan continues.
    pix_valid = 1'b1;
    pix_data  = tbl[1].data;
    tick();
    scan_check(43, tbl[0], "ovw_edge");
    pix_valid = 1'b0;
    for (int c = 44; c <= 61; c++) begin
      tick();
      scan_check(c, tbl[1], "ovw");
    end
    chk("ovw_count", 32'(update_count), 32'd2);

    // Reset while digit 3 is selected.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("mid_reset");
    tick();
    tick();
    chk_zero("post_reset_idle");

    // Saturating capture counter.
    pix_data  = 32'h00000001;
    pix_valid = 1'b1;
    repeat (65534) tick();
    chk("count_65534", 32'(update_count), 32'hFFFE);
    tick();
    chk("count_65535", 32'(update_count), 32'hFFFF);
    repeat (70000 - 65535) tick();
    chk("count_sat", 32'(update_count), 32'hFFFF);
    pix_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
